// File: rtl/tt_um_onehot_decoder_if.sv
// Pin-frame bundle for the one-hot decoder: the Tiny Tapeout ui/uo/uio buses plus ena.
// The master side drives codes and control bits; the slave side (the decoder) drives the read-back and status pins.
interface tt_um_onehot_decoder_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (
      output ena,
      output ui_in,
      output uio_in,
      input  uo_out,
      input  uio_out,
      input  uio_oe
   );

   modport slave (
      input  ena,
      input  ui_in,
      input  uio_in,
      output uo_out,
      output uio_out,
      output uio_oe
   );
endinterface

// File: rtl/tt_um_onehot_decoder.sv
// Rebuilds the 16-bit pattern from a priority-encoder code on a strobe edge, with replace/OR update and a sticky error flag.
// Optional macro ONEHOT_DEC_THERMO_EN turns the VALID pattern into a thermometer code (bits [index:0] set).
module tt_um_onehot_decoder (
   input  logic                          clk,
   input  logic                          rst_n,
   tt_um_onehot_decoder_if.slave         bus
);

   logic        strb;
   logic        acc;
   logic        clr;
   logic        sel0;
   logic        unused_ok;

   logic        strb_q;
   logic        accept;
   logic [15:0] mask;
   logic        err;
   logic [3:0]  cnt;
   logic [7:0]  last_code;
   logic        ack;

   logic        code_valid;
   logic        code_none;
   logic [15:0] pattern;
   logic        nz;
   logic [7:0]  rd_byte;

   assign strb = bus.uio_in[0];
   assign acc  = bus.uio_in[1];
   assign clr  = bus.uio_in[2];
   assign sel0 = bus.uio_in[3];

   assign unused_ok = &{1'b0, bus.ena, bus.uio_in[7:4]};

   assign accept     = strb & ~strb_q;
   assign code_valid = (bus.ui_in[7:4] == 4'h0);
   assign code_none  = (bus.ui_in == 8'hF0);

`ifdef ONEHOT_DEC_THERMO_EN
   always_comb begin
      pattern = 16'h0000;
      for (int k = 0; k < 16; k++) begin
         pattern[k] = (4'(k) <= bus.ui_in[3:0]);
      end
   end
`else
   always_comb begin
      pattern = 16'h0001 << bus.ui_in[3:0];
   end
`endif

   // clr wins over a coincident strobe edge; the edge is consumed (strb_q still follows strb).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         strb_q    <= 1'b1;
         mask      <= 16'h0000;
         err       <= 1'b0;
         cnt       <= 4'h0;
         last_code <= 8'h00;
         ack       <= 1'b0;
      end else begin
         strb_q <= strb;
         ack    <= 1'b0;
         if (clr) begin
            mask <= 16'h0000;
            err  <= 1'b0;
            cnt  <= 4'h0;
         end else if (accept) begin
            last_code <= bus.ui_in;
            ack       <= 1'b1;
            if (code_valid) begin
               mask <= acc ? (mask | pattern) : pattern;
               cnt  <= cnt + 4'h1;
            end else if (code_none) begin
               mask <= acc ? mask : 16'h0000;
               cnt  <= cnt + 4'h1;
            end else begin
               err <= 1'b1;
            end
         end
      end
   end

   assign nz = |mask;

   always_comb begin
      rd_byte = 8'h00;
      unique case ({acc, sel0})
         2'b00: rd_byte = mask[7:0];
         2'b01: rd_byte = mask[15:8];
         2'b10: rd_byte = {cnt, err, nz, 2'b00};
         2'b11: rd_byte = last_code;
         default: rd_byte = 8'h00;
      endcase
   end

   assign bus.uo_out  = rd_byte;
   assign bus.uio_out = {1'b0, ack, nz, err, 4'b0000};
   assign bus.uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_onehot_decoder.sv
// Directed and randomized bench for tt_um_onehot_decoder against an arithmetic reference model.
`timescale 1ns/1ps
module tb_tt_um_onehot_decoder;

   logic clk;
   logic rst_n;
   logic strb, acc, clr, sel0;
   int   checks;
   int   errors;

   int   m_mask, m_err, m_cnt, m_last, m_ack, m_strb_q;

   tt_um_onehot_decoder_if bus ();

   tt_um_onehot_decoder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign bus.uio_in = {4'b0000, sel0, clr, acc, strb};

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pat_of(input int idx);
`ifdef ONEHOT_DEC_THERMO_EN
      return ((1 << (idx + 1)) - 1) & 16'hFFFF;
`else
      return 1 << idx;
`endif
   endfunction

   // Model the effect of the upcoming edge from the current inputs, then clock and compare everything visible.
   task automatic tick(input string tag);
      int code;
      int exp_nz;
      int exp_rd;
      logic save_acc, save_sel;
      code = int'(bus.ui_in);
      if (!rst_n) begin
         m_mask = 0; m_err = 0; m_cnt = 0; m_last = 0; m_ack = 0; m_strb_q = 1;
      end else begin
         bit edge_seen;
         edge_seen = strb && (m_strb_q == 0);
         m_strb_q  = strb;
         m_ack     = 0;
         if (clr) begin
            m_mask = 0; m_err = 0; m_cnt = 0;
         end else if (edge_seen) begin
            m_last = code;
            m_ack  = 1;
            if (code < 16) begin
               m_mask = acc ? (m_mask | pat_of(code)) : pat_of(code);
               m_cnt  = (m_cnt + 1) % 16;
            end else if (code == 8'hF0) begin
               if (!acc) m_mask = 0;
               m_cnt = (m_cnt + 1) % 16;
            end else begin
               m_err = 1;
            end
         end
      end
      @(posedge clk);
      #1;
      exp_nz = (m_mask != 0) ? 1 : 0;
      chk({tag, ":uio_out"}, 16'(bus.uio_out), 16'((m_ack << 6) | (exp_nz << 5) | (m_err << 4)));
      chk({tag, ":uio_oe"}, 16'(bus.uio_oe), 16'h00F0);
      save_acc = acc;
      save_sel = sel0;
      for (int v = 0; v < 4; v++) begin
         {acc, sel0} = 2'(v);
         #1;
         case (v)
            0: exp_rd = m_mask & 8'hFF;
            1: exp_rd = (m_mask >> 8) & 8'hFF;
            2: exp_rd = (m_cnt << 4) | (m_err << 3) | (exp_nz << 2);
            default: exp_rd = m_last;
         endcase
         chk($sformatf("%s:rd%0d", tag, v), 16'(bus.uo_out), 16'(exp_rd));
      end
      acc  = save_acc;
      sel0 = save_sel;
   endtask

   task automatic load(input string tag, input logic [7:0] code, input logic a);
      strb = 1'b0;
      tick({tag, ":lo"});
      bus.ui_in = code;
      acc  = a;
      strb = 1'b1;
      tick({tag, ":hi"});
   endtask

   task automatic pulse_clr(input string tag);
      clr = 1'b1;
      tick(tag);
      clr = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0;
      m_mask = 0; m_err = 0; m_cnt = 0; m_last = 0; m_ack = 0; m_strb_q = 1;
      bus.ena = 1'b1;
      bus.ui_in = 8'd0;
      strb = 1'b1; acc = 1'b0; clr = 1'b0; sel0 = 1'b0;
      rst_n = 1'b0;
      tick("rst0");
      tick("rst1");
      rst_n = 1'b1;
      bus.ui_in = 8'd3;
      tick("held0");
      tick("held1");
      chk("no_ack_after_reset", 16'(bus.uio_out[6]), 16'h0000);

      load("c3", 8'd3, 1'b0);
      chk("c3_ack", 16'(bus.uio_out[6]), 16'h0001);
      strb = 1'b1;
      tick("c3_ackdrop");

      load("r15", 8'd15, 1'b0);
      load("r0", 8'd0, 1'b0);
      load("r4", 8'd4, 1'b0);

      pulse_clr("clr_a");
      load("a1", 8'd1, 1'b1);
      load("a9", 8'd9, 1'b1);
      load("aF0", 8'hF0, 1'b1);
      load("rF0", 8'hF0, 1'b0);

      load("v5", 8'd5, 1'b0);
      load("bad35", 8'h35, 1'b0);
      load("v7", 8'd7, 1'b1);
      load("badFF", 8'hFF, 1'b1);
      pulse_clr("clr_b");

      for (int i = 0; i < 17; i++) load($sformatf("wrap%0d", i), 8'(i % 16), 1'b1);

      load("pre", 8'd6, 1'b0);
      strb = 1'b0;
      tick("coinc_lo");
      bus.ui_in = 8'd2;
      strb = 1'b1;
      clr  = 1'b1;
      tick("coinc");
      clr = 1'b0;
      tick("coinc_after");

      for (int i = 0; i < 120; i++) begin
         case ($urandom_range(0, 3))
            0, 1: bus.ui_in = 8'($urandom_range(0, 15));
            2:    bus.ui_in = 8'hF0;
            default: bus.ui_in = 8'($urandom_range(0, 255));
         endcase
         strb = 1'($urandom_range(0, 1));
         acc  = 1'($urandom_range(0, 1));
         sel0 = 1'($urandom_range(0, 1));
         clr  = ($urandom_range(0, 11) == 0);
         rst_n = ($urandom_range(0, 39) != 0);
         tick($sformatf("rnd%0d", i));
      end
      rst_n = 1'b1;
      clr = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
